// File: rtl/divctl_pkg.sv
// Shared definitions for the divider issue/retire wrapper: op encodings and
// the per-operation side information carried from issue to retire.
package divctl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef struct packed {
    op_e  op;
    logic neg_q;
    logic neg_r;
    logic dz;
  } side_info_t;

  localparam int unsigned SIDE_INFO_W = $bits(side_info_t);

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/divctl_fifo.sv
// Synchronous FIFO, sync active-low reset. A pop on an empty FIFO is ignored
// (no bypass); a push at full is accepted only together with a pop.
module divctl_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/divctl.sv
// Issue/retire wrapper for the unsigned pipelined divider core: sign handling,
// in-order side tracking, result buffering and credit-based admission.
module divctl
  import divctl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            core_vld,
  output logic [XLEN-1:0] core_a,
  output logic [XLEN-1:0] core_b,
  input  logic            core_ack,
  input  logic [XLEN-1:0] core_quo,
  input  logic [XLEN-1:0] core_rem,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_data,
  output logic [TAGW-1:0] out_tag
);

  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned SIDE_W = SIDE_INFO_W + TAGW;
  localparam int unsigned RES_W  = XLEN + TAGW;

  logic [CW-1:0]     r_credits;
  op_e               w_in_op;
  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_retire;
  logic              w_side_empty;
  logic              w_res_empty;
  side_info_t        w_push_info;
  side_info_t        w_pop_info;
  logic [TAGW-1:0]   w_pop_tag;
  logic [SIDE_W-1:0] w_side_rdata;
  logic [RES_W-1:0]  w_res_rdata;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_res_data;

  assign w_in_op  = op_e'(in_op);
  assign in_rdy   = rst_n & (r_credits != '0);
  assign w_accept = in_vld & in_rdy;
  assign core_vld = w_accept;
  assign out_vld  = ~w_res_empty;
  assign w_out_hs = out_vld & out_rdy;
  assign w_retire = core_ack & ~w_side_empty;

  always_comb begin
    w_neg_a     = is_signed_op(w_in_op) & in_a[XLEN-1];
    w_neg_b     = is_signed_op(w_in_op) & in_b[XLEN-1];
    core_a      = w_neg_a ? -in_a : in_a;
    core_b      = w_neg_b ? -in_b : in_b;
    w_push_info = '{op: w_in_op, neg_q: w_neg_a ^ w_neg_b, neg_r: w_neg_a, dz: (in_b == '0)};
  end

  divctl_fifo #(.W(SIDE_W), .DEPTH(DEPTH)) u_side_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_accept),
    .i_wdata ({w_push_info, in_tag}),
    .i_pop   (w_retire),
    .o_rdata (w_side_rdata),
    .o_empty (w_side_empty)
  );

  assign {w_pop_info, w_pop_tag} = w_side_rdata;

  // A zero divisor leaves the core remainder equal to the magnitude of the
  // dividend, so only the quotient needs overriding.
  always_comb begin
    w_q = w_pop_info.neg_q ? -core_quo : core_quo;
    if (w_pop_info.dz) w_q = '1;
    w_r = w_pop_info.neg_r ? -core_rem : core_rem;
    case (w_pop_info.op)
      OP_REM, OP_REMU: w_res_data = w_r;
      default:         w_res_data = w_q;
    endcase
  end

  divctl_fifo #(.W(RES_W), .DEPTH(DEPTH)) u_res_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_retire),
    .i_wdata ({w_res_data, w_pop_tag}),
    .i_pop   (w_out_hs),
    .o_rdata (w_res_rdata),
    .o_empty (w_res_empty)
  );

  assign {out_data, out_tag} = w_res_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_credits <= CW'(DEPTH);
    end else begin
      case ({w_accept, w_out_hs})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

endmodule

// File: tb/tb_divctl.sv
// Directed bench for divctl with a behavioural model of a 3-stage divider core.
module tb_divctl;
  import divctl_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned NST   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_vld;
  logic            in_rdy;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [TAGW-1:0] in_tag;
  logic            core_vld;
  logic [XLEN-1:0] core_a;
  logic [XLEN-1:0] core_b;
  logic            core_ack;
  logic [XLEN-1:0] core_quo;
  logic [XLEN-1:0] core_rem;
  logic            out_vld;
  logic            out_rdy;
  logic [XLEN-1:0] out_data;
  logic [TAGW-1:0] out_tag;

  int checks   = 0;
  int failures = 0;
  int outst    = 0;
  int orphans  = 0;

  always #5 clk = ~clk;

  divctl #(.XLEN(XLEN), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .core_vld (core_vld),
    .core_a   (core_a),
    .core_b   (core_b),
    .core_ack (core_ack),
    .core_quo (core_quo),
    .core_rem (core_rem),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  // Divider core model: fixed NST register stages, no stall, reset with the block.
  logic [NST-1:0]  cv;
  logic [XLEN-1:0] ca [NST];
  logic [XLEN-1:0] cb [NST];

  always @(posedge clk) begin
    if (!rst_n) cv <= '0;
    else        cv <= {cv[NST-2:0], core_vld};
    ca[0] <= core_a;
    cb[0] <= core_b;
    for (int i = 1; i < NST; i++) begin
      ca[i] <= ca[i-1];
      cb[i] <= cb[i-1];
    end
  end

  assign core_ack = cv[NST-1];
  assign core_quo = (cb[NST-1] == '0) ? '1 : ca[NST-1] / cb[NST-1];
  assign core_rem = (cb[NST-1] == '0) ? ca[NST-1] : ca[NST-1] % cb[NST-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      outst <= 0;
    end else begin
      if (core_ack && outst == 0) orphans <= orphans + 1;
      outst <= outst + (core_vld ? 1 : 0) - (core_ack ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    int n = 0;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_vld = 1'b1;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_rdy", {31'b0, in_rdy}, 1);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic get_res(input string name, input logic [31:0] exp_d, input logic [3:0] exp_t);
    int n = 0;
    while (!out_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_vld"}, {31'b0, out_vld}, 1);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_tag"}, {28'b0, out_tag}, {28'b0, exp_t});
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic set_burst(input int i);
    in_op  = OP_DIVU;
    in_a   = 32'(10 * (i + 1));
    in_b   = 32'd5;
    in_tag = 4'(i);
  endtask

  logic [1:0]  v_op [11] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_REM,
                             OP_DIVU, OP_REMU, OP_DIV, OP_REM};
  logic [31:0] v_a  [11] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'd5, 32'hFFFFFFFB,
                             32'hFFFFFFFB, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] v_b  [11] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_e  [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    int cnt;
    int acc;
    logic seen;
    rst_n = 1'b0; in_vld = 1'b1; in_op = OP_DIVU; in_a = 32'd1; in_b = 32'd1; in_tag = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", {31'b0, in_rdy}, 0);
    chk("rst_core_vld", {31'b0, core_vld}, 0);
    chk("rst_out_vld", {31'b0, out_vld}, 0);
    in_vld = 1'b0;
    rst_n  = 1'b1;
    #1;
    chk("post_rst_in_rdy", {31'b0, in_rdy}, 1);

    in_op = OP_DIV; in_a = 32'hFFFFFFF9; in_b = 32'hFFFFFFFE; #1;
    chk("mag_a_neg", core_a, 32'd7);
    chk("mag_b_neg", core_b, 32'd2);
    in_op = OP_DIVU; #1;
    chk("mag_a_unsigned", core_a, 32'hFFFFFFF9);
    in_op = OP_REM; in_a = 32'h80000000; in_b = 32'hFFFFFFFF; #1;
    chk("mag_a_min", core_a, 32'h80000000);
    chk("mag_b_m1", core_b, 32'd1);
    @(negedge clk);

    do_op(OP_DIVU, 32'd100, 32'd7, 4'd1);
    do_op(OP_REMU, 32'd100, 32'd7, 4'd2);
    get_res("divu_100_7", 32'd14, 4'd1);
    get_res("remu_100_7", 32'd2, 4'd2);

    do_op(OP_DIVU, 32'd1000, 32'd10, 4'd0);
    cnt = 0;
    while (!out_vld && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(NST));
    get_res("divu_1000_10", 32'd100, 4'd0);

    for (int i = 0; i < 11; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], 4'(i + 3));
      get_res($sformatf("vec%0d", i), v_e[i], 4'(i + 3));
    end

    acc = 0;
    set_burst(acc);
    in_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (in_rdy) acc++;
      @(negedge clk);
      set_burst(acc);
    end
    chk("bp_accepts", 32'(acc), 32'(DEPTH));
    chk("bp_in_rdy", {31'b0, in_rdy}, 0);

    out_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("tp_vld%0d", k), {31'b0, out_vld}, 1);
      chk($sformatf("tp_tag%0d", k), {28'b0, out_tag}, {28'b0, 4'(k)});
      chk($sformatf("tp_data%0d", k), out_data, 32'(2 * (k + 1)));
      if (k >= 1) chk($sformatf("tp_in_rdy%0d", k), {31'b0, in_rdy}, 1);
      if (in_rdy) acc++;
      @(negedge clk);
      set_burst(acc);
    end
    in_vld = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_out_vld", {31'b0, out_vld}, 0);
    chk("drain_in_rdy", {31'b0, in_rdy}, 1);
    out_rdy = 1'b0;

    do_op(OP_DIVU, 32'd9, 32'd3, 4'd8);
    do_op(OP_DIVU, 32'd8, 32'd2, 4'd9);
    do_op(OP_DIVU, 32'd6, 32'd2, 4'd10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      if (out_vld) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_no_out", {31'b0, seen}, 0);
    chk("rst_mid_in_rdy", {31'b0, in_rdy}, 1);
    do_op(OP_DIV, 32'd9, 32'd3, 4'd11);
    get_res("after_rst", 32'd3, 4'd11);

    chk("ack_without_entry", 32'(orphans), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
